// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver.
// Recovers start / data (LSB first) / optional parity / stop frames from RX_IN,
// votes each bit from three samples around the bit centre, and reports each
// frame as either a good byte (data_valid) or an error pulse (par_err/stp_err).
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [PRESC_W-1:0]      edge_cnt_reg;
    logic [BIT_W-1:0]        bit_cnt_reg;
    logic [PRESC_W-1:0]      presc_reg;
    logic                    par_en_reg;
    logic                    par_typ_reg;
    logic                    par_mm_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;

    // Per-frame timing points derived from the prescale latched at frame start.
    logic [PRESC_W-1:0]      half_edge;
    logic [PRESC_W-1:0]      last_edge;
    logic                    bit_end;
    logic [2:0]              sample_vec;
    logic                    bit_value;

    assign half_edge = presc_reg >> 1;
    assign last_edge = presc_reg - PRESC_W'(1);
    assign bit_end   = (edge_cnt_reg == last_edge);

    // Three samples taken on consecutive clocks centred on the middle of the bit.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sample
            logic [PRESC_W-1:0] sample_edge;
            logic               smp_reg;

            assign sample_edge = half_edge + PRESC_W'(gi) - PRESC_W'(1);

            // Capture RX_IN when the bit-period counter reaches this sample point.
            always_ff @(posedge clk or negedge RST) begin
                if (!RST) begin
                    smp_reg <= 1'b1;
                end else if ((state_reg != IDLE) && (edge_cnt_reg == sample_edge)) begin
                    smp_reg <= RX_IN;
                end
            end

            assign sample_vec[gi] = smp_reg;
        end
    endgenerate

    // 2-of-3 vote rejects a single-clock glitch on any one sample.
    assign bit_value = (sample_vec[0] & sample_vec[1]) |
                       (sample_vec[0] & sample_vec[2]) |
                       (sample_vec[1] & sample_vec[2]);

    // Frame FSM with bit-period counter, shift register and registered result pulses.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            presc_reg    <= PRESC_W'(8);
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
            par_mm_reg   <= 1'b0;
            shift_reg    <= '0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            // Result outputs are single-cycle pulses unless set below.
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state_reg == IDLE) begin
                edge_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else if (bit_end) begin
                edge_cnt_reg <= '0;
            end else begin
                edge_cnt_reg <= edge_cnt_reg + PRESC_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (!RX_IN) begin
                        // The detecting clock is position 0 of the start bit.
                        state_reg    <= START;
                        edge_cnt_reg <= PRESC_W'(1);
                        presc_reg    <= Prescale;
                        par_en_reg   <= PAR_EN;
                        par_typ_reg  <= PAR_TYP;
                        par_mm_reg   <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        // A start bit that votes high was line noise: drop it silently.
                        state_reg <= bit_value ? IDLE : DATA;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {bit_value, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= par_en_reg ? PARITY : STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        // Even parity bit equals XOR of data; odd parity is its inverse.
                        par_mm_reg <= bit_value ^ (^shift_reg) ^ par_typ_reg;
                        state_reg  <= STOP;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state_reg <= IDLE;
                        if (bit_value && !par_mm_reg) begin
                            P_DATA     <= shift_reg;
                            data_valid <= 1'b1;
                        end else if (par_mm_reg) begin
                            par_err <= 1'b1;
                            stp_err <= ~bit_value;
                        end else begin
                            stp_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed, table-driven checks of uart_rx_core frame handling.
module tb_uart_rx_core;

    logic       clk;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int tests;
    int fails;
    int dv_cnt;
    int pe_cnt;
    int se_cnt;

    uart_rx_core #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk        (clk),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (data_valid) dv_cnt++;
        if (par_err)    pe_cnt++;
        if (stp_err)    se_cnt++;
    end

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        bit         par_bit;
        logic [7:0] data;
        bit         stop;
        bit         glitch;
        bit         mess;
        bit         exp_dv;
        bit         exp_pe;
        bit         exp_se;
        logic [7:0] exp_pd;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one bit period starting at a falling edge; optional flip on the centre clock.
    task automatic drive_bit(input bit b, input int p, input bit glitch);
        for (int i = 0; i < p; i++) begin
            RX_IN = (glitch && (i == p / 2)) ? ~b : b;
            @(negedge clk);
        end
    endtask

    // Full frame; returns on the falling edge after the last stop-bit clock.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input bit par_bit,
                              input logic [7:0] data, input bit stop, input bit glitch,
                              input bit mess);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        @(negedge clk);
        if (mess) begin
            Prescale = 6'd32;
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
        end
        repeat (p - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p, glitch);
        if (pen) drive_bit(par_bit, p, 1'b0);
        drive_bit(stop, p, 1'b0);
    endtask

    initial begin
        int dv0;
        int pe0;
        int se0;

        tests = 0; fails = 0; dv_cnt = 0; pe_cnt = 0; se_cnt = 0;

        //          p  pen ptyp par data   stp glt mes  dv pe se  pd
        vecs[0]  = '{8,  1, 0, 0, 8'hA5, 1, 0, 0,  1, 0, 0, 8'hA5};
        vecs[1]  = '{16, 1, 0, 0, 8'h01, 1, 0, 0,  0, 1, 0, 8'hA5};
        vecs[2]  = '{32, 0, 0, 0, 8'h5A, 0, 0, 0,  0, 0, 1, 8'hA5};
        vecs[3]  = '{8,  1, 1, 1, 8'h5A, 1, 0, 0,  1, 0, 0, 8'h5A};
        vecs[4]  = '{16, 1, 1, 0, 8'h07, 0, 0, 0,  0, 0, 1, 8'h5A};
        vecs[5]  = '{8,  1, 0, 1, 8'h03, 0, 0, 0,  0, 1, 1, 8'h5A};
        vecs[6]  = '{32, 0, 0, 0, 8'h00, 1, 0, 0,  1, 0, 0, 8'h00};
        vecs[7]  = '{16, 0, 0, 0, 8'hFF, 1, 0, 0,  1, 0, 0, 8'hFF};
        vecs[8]  = '{8,  0, 0, 0, 8'hC9, 1, 1, 0,  1, 0, 0, 8'hC9};
        vecs[9]  = '{8,  0, 0, 0, 8'h81, 1, 0, 1,  1, 0, 0, 8'h81};
        vecs[10] = '{16, 1, 1, 1, 8'h96, 1, 1, 0,  1, 0, 0, 8'h96};

        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        repeat (3) @(negedge clk);
        check("reset_pdata", P_DATA, 8'h00);
        check("reset_pulses", {data_valid, par_err, stp_err}, 3'b000);
        RST = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven frames.
        for (int v = 0; v < 11; v++) begin
            dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
            send_frame(vecs[v].p, vecs[v].pen, vecs[v].ptyp, vecs[v].par_bit, vecs[v].data,
                       vecs[v].stop, vecs[v].glitch, vecs[v].mess);
            RX_IN = 1'b1;
            $display("[TB] frame %0d presc=%0d data=%02h -> dv=%b pe=%b se=%b P_DATA=%02h",
                     v, vecs[v].p, vecs[v].data, data_valid, par_err, stp_err, P_DATA);
            check($sformatf("v%0d_data_valid", v), data_valid, vecs[v].exp_dv);
            check($sformatf("v%0d_par_err", v), par_err, vecs[v].exp_pe);
            check($sformatf("v%0d_stp_err", v), stp_err, vecs[v].exp_se);
            check($sformatf("v%0d_p_data", v), P_DATA, vecs[v].exp_pd);
            @(negedge clk);
            check($sformatf("v%0d_pulse_width", v), {data_valid, par_err, stp_err}, 3'b000);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_dv_count", v), dv_cnt - dv0, vecs[v].exp_dv);
            check($sformatf("v%0d_pe_count", v), pe_cnt - pe0, vecs[v].exp_pe);
            check($sformatf("v%0d_se_count", v), se_cnt - se0, vecs[v].exp_se);
        end

        // False start: line low for 2 clocks only.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        Prescale = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (40) @(negedge clk);
        $display("[TB] false start -> pulses=%0d P_DATA=%02h",
                 (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), P_DATA);
        check("glitch_start_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        check("glitch_start_pdata", P_DATA, 8'h96);

        // Back-to-back frames with no idle gap.
        dv0 = dv_cnt;
        send_frame(16, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
        $display("[TB] b2b first -> dv=%b P_DATA=%02h", data_valid, P_DATA);
        check("b2b_first_dv", data_valid, 1'b1);
        check("b2b_first_pdata", P_DATA, 8'h3C);
        send_frame(16, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);
        RX_IN = 1'b1;
        $display("[TB] b2b second -> dv=%b P_DATA=%02h", data_valid, P_DATA);
        check("b2b_second_dv", data_valid, 1'b1);
        check("b2b_second_pdata", P_DATA, 8'hC3);
        repeat (4) @(negedge clk);
        check("b2b_dv_count", dv_cnt - dv0, 2);

        // Reset in the middle of a 0xFF frame, then a glitched 0x12 frame.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        Prescale = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 8, 1'b0);
        repeat (3) @(negedge clk);
        RST = 1'b0;
        #1;
        $display("[TB] reset mid-frame -> P_DATA=%02h dv=%b", P_DATA, data_valid);
        check("async_reset_pdata", P_DATA, 8'h00);
        check("async_reset_pulses", {data_valid, par_err, stp_err}, 3'b000);
        repeat (2) @(negedge clk);
        RST = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_no_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b1, 1'b0);
        RX_IN = 1'b1;
        $display("[TB] post-reset frame -> dv=%b P_DATA=%02h", data_valid, P_DATA);
        check("post_reset_dv", data_valid, 1'b1);
        check("post_reset_pdata", P_DATA, 8'h12);
        repeat (4) @(negedge clk);
        check("post_reset_dv_count", dv_cnt - dv0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
